// File: rtl/commit_trace_serializer.sv
// commit_trace_serializer
// Narrows the dual-retire ROB commit bus to a single harness commit lane.
// Retired uops are compacted into a small FIFO and drained one per cycle
// through a registered head, in program order.
// Optional feature macro: COMMIT_TRACE_VEC_EN carries the vector writeback
// data and mask through the buffer. Without it, the vector outputs are tied
// to zero and the vector inputs are ignored.
module commit_trace_serializer #(
    parameter int VLEN  = 256,
    parameter int DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid_0,
    input  logic                      in_valid_1,
    output logic                      in_ready,
    input  logic [4:0]                in_uops_0_ldst,
    input  logic [2:0]                in_uops_0_dst_rtype,
    input  logic [39:0]               in_uops_0_debug_pc,
    input  logic [63:0]               in_uops_0_debug_tag,
    input  logic [63:0]               in_uops_0_debug_wdata,
    input  logic [VLEN*8-1:0]         in_uops_0_debug_vec_wdata,
    input  logic [7:0]                in_uops_0_debug_vec_wmask,
    input  logic [31:0]               in_uops_0_debug_inst,
    input  logic [4:0]                in_uops_1_ldst,
    input  logic [2:0]                in_uops_1_dst_rtype,
    input  logic [39:0]               in_uops_1_debug_pc,
    input  logic [63:0]               in_uops_1_debug_tag,
    input  logic [63:0]               in_uops_1_debug_wdata,
    input  logic [VLEN*8-1:0]         in_uops_1_debug_vec_wdata,
    input  logic [7:0]                in_uops_1_debug_vec_wmask,
    input  logic [31:0]               in_uops_1_debug_inst,
    input  logic                      out_ready,
    output logic                      commit_arch_valids_0,
    output logic [4:0]                commit_uops_0_ldst,
    output logic [2:0]                commit_uops_0_dst_rtype,
    output logic [39:0]               commit_uops_0_debug_pc,
    output logic [63:0]               commit_uops_0_debug_tag,
    output logic [63:0]               commit_uops_0_debug_wdata,
    output logic [VLEN*8-1:0]         commit_uops_0_debug_vec_wdata,
    output logic [7:0]                commit_uops_0_debug_vec_wmask,
    output logic [31:0]               commit_uops_0_debug_inst,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      err_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int VW    = VLEN * 8;

    typedef struct packed {
`ifdef COMMIT_TRACE_VEC_EN
        logic [VW-1:0] vec_wdata;
        logic [7:0]    vec_wmask;
`endif
        logic [4:0]    ldst;
        logic [2:0]    dst_rtype;
        logic [39:0]   pc;
        logic [63:0]   tag;
        logic [63:0]   wdata;
        logic [31:0]   inst;
    } uop_t;

    uop_t              mem [DEPTH];
    uop_t              head_q;
    logic              head_valid;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  wr_ptr_p1;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ_q;
    logic              err_q;

    uop_t              lane0;
    uop_t              lane1;
    uop_t              first_uop;
    uop_t              mem_wr_a;
    logic              accept_0;
    logic              accept_1;
    logic [1:0]        push_cnt;
    logic [1:0]        mem_wr_cnt;
    logic              pop;
    logic              head_take;
    logic              mem_empty;
    logic              mem_rd;
    logic              bypass;

    // Room for a full retire group is judged from registered occupancy only,
    // which keeps out_ready off the ROB back-pressure path.
    assign in_ready = (occ_q <= OCC_W'(DEPTH - 2));

    // Pack the lanes, compact them, and decide where each accepted uop goes:
    // straight into an empty/draining head, or into the storage ring.
    always_comb begin
        lane0           = '0;
        lane1           = '0;
        lane0.ldst      = in_uops_0_ldst;
        lane0.dst_rtype = in_uops_0_dst_rtype;
        lane0.pc        = in_uops_0_debug_pc;
        lane0.tag       = in_uops_0_debug_tag;
        lane0.wdata     = in_uops_0_debug_wdata;
        lane0.inst      = in_uops_0_debug_inst;
        lane1.ldst      = in_uops_1_ldst;
        lane1.dst_rtype = in_uops_1_dst_rtype;
        lane1.pc        = in_uops_1_debug_pc;
        lane1.tag       = in_uops_1_debug_tag;
        lane1.wdata     = in_uops_1_debug_wdata;
        lane1.inst      = in_uops_1_debug_inst;
`ifdef COMMIT_TRACE_VEC_EN
        lane0.vec_wdata = in_uops_0_debug_vec_wdata;
        lane0.vec_wmask = in_uops_0_debug_vec_wmask;
        lane1.vec_wdata = in_uops_1_debug_vec_wdata;
        lane1.vec_wmask = in_uops_1_debug_vec_wmask;
`endif
        accept_0   = in_valid_0 & in_ready;
        accept_1   = in_valid_1 & in_ready;
        push_cnt   = {1'b0, accept_0} + {1'b0, accept_1};
        first_uop  = in_valid_0 ? lane0 : lane1;
        pop        = head_valid & out_ready;
        head_take  = ~head_valid | pop;
        mem_empty  = (occ_q == {{(OCC_W-1){1'b0}}, head_valid});
        mem_rd     = head_take & ~mem_empty;
        bypass     = head_take & mem_empty & (push_cnt != 2'd0);
        mem_wr_cnt = push_cnt - {1'b0, bypass};
        mem_wr_a   = bypass ? lane1 : first_uop;
        wr_ptr_p1  = wr_ptr + PTR_W'(1);
    end

    // Storage ring writes; the second write only happens for an unbypassed dual push.
    always_ff @(posedge clock) begin
        if (mem_wr_cnt != 2'd0) begin
            mem[wr_ptr] <= mem_wr_a;
        end
        if (mem_wr_cnt == 2'd2) begin
            mem[wr_ptr_p1] <= lane1;
        end
    end

    // Pointers, occupancy, sticky error and the registered output head.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ_q      <= '0;
            err_q      <= 1'b0;
            head_valid <= 1'b0;
            head_q     <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(mem_wr_cnt);
            if (mem_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ_q <= occ_q + OCC_W'(push_cnt) - OCC_W'(pop);
            if ((in_valid_0 | in_valid_1) & ~in_ready) begin
                err_q <= 1'b1;
            end
            if (head_take) begin
                if (mem_rd) begin
                    head_q     <= mem[rd_ptr];
                    head_valid <= 1'b1;
                end else if (bypass) begin
                    head_q     <= first_uop;
                    head_valid <= 1'b1;
                end else begin
                    head_valid <= 1'b0;
                end
            end
        end
    end

    assign commit_arch_valids_0      = head_valid;
    assign commit_uops_0_ldst        = head_q.ldst;
    assign commit_uops_0_dst_rtype   = head_q.dst_rtype;
    assign commit_uops_0_debug_pc    = head_q.pc;
    assign commit_uops_0_debug_tag   = head_q.tag;
    assign commit_uops_0_debug_wdata = head_q.wdata;
    assign commit_uops_0_debug_inst  = head_q.inst;
    assign occupancy                 = occ_q;
    assign err_overflow              = err_q;

`ifdef COMMIT_TRACE_VEC_EN
    assign commit_uops_0_debug_vec_wdata = head_q.vec_wdata;
    assign commit_uops_0_debug_vec_wmask = head_q.vec_wmask;
`else
    logic unused_vec_inputs;
    assign unused_vec_inputs = ^{in_uops_0_debug_vec_wdata, in_uops_0_debug_vec_wmask,
                                 in_uops_1_debug_vec_wdata, in_uops_1_debug_vec_wmask};
    assign commit_uops_0_debug_vec_wdata = '0;
    assign commit_uops_0_debug_vec_wmask = '0;
`endif

endmodule
